status_reg_unit: RTL and testbench
==================================

Name: status_reg_unit

Overview:
- Parametrised successor to the combinational status read-out (LSTAT).
- Owns the CPU status/flag register and updates flags from the ALU under a per-bit mask.
- Serves LSTAT (status -> data bus, zero-extended) and SSTAT (data bus -> status).
- Keeps a small hardware stack of status snapshots for interrupt/call context save/restore.
- Sits in ALU/program_flow, between the ALU flag outputs and the 20-bit data path.

Parameters:
- FLAG_W, 8, width of status register (1..DATA_W)
- DATA_W, 20, data bus width; LSTAT result zero-extended to this
- STACK_DEPTH, 4, number of status snapshots held (>=1)
- RESET_FLAGS, 8'h00 (FLAG_W bits), status value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- alu_flags  in  FLAG_W  new flag values from ALU
- alu_flags_we  in  FLAG_W  per-bit write mask for alu_flags
- lstat_req  in  1  request status read-out onto data_out
- sstat_we  in  1  load status from sstat_data[FLAG_W-1:0]
- sstat_data  in  DATA_W  data bus value for SSTAT
- push  in  1  save current status onto stack
- pop  in  1  restore status from stack top
- err_clr  in  1  clear sticky stack_err
- status  out  FLAG_W  current status register
- data_out  out  DATA_W  registered LSTAT result
- data_valid  out  1  one-cycle strobe: data_out updated
- depth  out  $clog2(STACK_DEPTH+1)  entries in stack
- stack_err  out  1  sticky overflow/underflow/conflict flag

Behaviour:
- Reset (rst_n low at clk edge):
  - status=RESET_FLAGS; data_out=0; data_valid=0; depth=0; stack_err=0.
  - Stack contents are don't-care.
  - Reset overrides every same-cycle request, including mid-operation ones.
- Status next-value priority per cycle, highest first:
  1. Valid pop: status <= stack top.
  2. sstat_we: status <= sstat_data[FLAG_W-1:0]; upper bits ignored.
  3. Masked ALU update: status[i] <= alu_flags_we[i] ? alu_flags[i] : status[i].
- All status writes take effect at the next edge; status output is the register.
- LSTAT:
  - lstat_req at edge N -> at edge N+1: data_out = {(DATA_W-FLAG_W)'0, status value before edge N's update}; data_valid=1 for exactly that one cycle.
  - data_out holds its value when there is no request.
  - Back-to-back requests give one strobe per cycle.
- Push:
  - Writes the pre-update status (value visible in that cycle) to stack[depth]; depth+1.
  - A same-cycle ALU/SSTAT update still applies to status.
- Pop:
  - status <= stack[depth-1]; depth-1. Overrides same-cycle sstat_we and ALU update.
- Boundary conditions:
  - Push when depth==STACK_DEPTH: ignored, depth unchanged, stack_err<=1.
  - Pop when depth==0: ignored; status updates per sstat/ALU as if no pop; stack_err<=1.
  - push&&pop same cycle: neither stack op occurs, stack_err<=1, status follows sstat/ALU.
  - err_clr clears stack_err unless a new error occurs the same cycle (set wins).
- Latency summary: status 1 cycle; LSTAT 1 cycle; no stalls, no backpressure.

Decomposition:
- Shared package program_flow_pkg holds:
  - Default FLAG_W and DATA_W constants.
  - Flag bit index constants (FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3, rest reserved).
  - Stack-op enum {NONE, PUSH, POP, CONFLICT}.
- Sub-module status_stack (LIFO: push/pop, depth, full/empty, error outputs).
- Top-level status_reg_unit holds the status register, the priority mux and the LSTAT output register.

Test Plan (FLAG_W=8, DATA_W=20, STACK_DEPTH=4, RESET_FLAGS=0):
1. Reset then lstat_req=1 for one cycle -> next cycle data_out=20'h00000, data_valid=1; following cycle data_valid=0.
2. sstat_data=20'hABCFF, sstat_we -> status=8'hFF; lstat_req -> data_out=20'h000FF; ALU flags=8'h00 with mask 8'h0F -> status=8'hF0.
3. sstat 8'h11, push; sstat 8'h22, push; sstat 8'h33 -> pop gives status=8'h22, depth=1; pop gives status=8'h11, depth=0, stack_err=0.
4. Five pushes from depth 0 -> depth=4, stack_err=1 after the fifth; err_clr -> stack_err=0; pop at depth 0 (after draining) -> stack_err=1, status unchanged.
5. Same cycle pop (top=8'h5A), sstat_we 8'hC3 and ALU mask 8'hFF -> status=8'h5A. Same cycle push&&pop -> depth unchanged, stack_err=1.
6. rst_n low during a push with lstat_req at depth 2 -> depth=0, status=0, data_valid=0, data_out=0 next cycle.

Source files
------------

// File: rtl/program_flow_pkg.sv
// Shared program-flow definitions: default widths, status flag bit positions
// and the decoded status-stack operation.
package program_flow_pkg;

    localparam int DEF_FLAG_W = 8;
    localparam int DEF_DATA_W = 20;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        STK_NONE     = 2'd0,
        STK_PUSH     = 2'd1,
        STK_POP      = 2'd2,
        STK_CONFLICT = 2'd3
    } stack_op_e;

    // push and pop together cancel both stack ops and count as an error
    function automatic stack_op_e decode_stack_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = STK_PUSH;
            2'b01:   op = STK_POP;
            2'b11:   op = STK_CONFLICT;
            default: op = STK_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/status_stack.sv
// LIFO of status snapshots. Rejected ops (overflow, underflow, push/pop conflict)
// leave the stack untouched and raise err_o for that cycle.
module status_stack
    import program_flow_pkg::*;
#(
    parameter int FLAG_W = DEF_FLAG_W,
    parameter int DEPTH  = 4,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  stack_op_e         op_i,
    input  logic [FLAG_W-1:0] wr_data_i,
    output logic [FLAG_W-1:0] top_o,
    output logic [DW-1:0]     depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] mem_q [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic              push_ok, pop_ok;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign push_ok = (op_i == STK_PUSH) && !full_o;
    assign pop_ok  = (op_i == STK_POP) && !empty_o;
    assign err_o   = ((op_i == STK_PUSH) && full_o) ||
                     ((op_i == STK_POP) && empty_o) ||
                     (op_i == STK_CONFLICT);

    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));
    assign top_o   = mem_q[rd_idx];
    assign depth_o = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (push_ok)
            depth_d = depth_q + DW'(1);
        else if (pop_ok)
            depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push_ok)
            mem_q[wr_idx] <= wr_data_i;
    end

endmodule

// File: rtl/status_reg_unit.sv
// CPU status register with masked ALU flag update, LSTAT/SSTAT transfer to the
// data bus and a snapshot stack for context save/restore.
module status_reg_unit
    import program_flow_pkg::*;
#(
    parameter int              FLAG_W      = DEF_FLAG_W,
    parameter int              DATA_W      = DEF_DATA_W,
    parameter int              STACK_DEPTH = 4,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = '0,
    localparam int             DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [FLAG_W-1:0] alu_flags_we,
    input  logic              lstat_req,
    input  logic              sstat_we,
    input  logic [DATA_W-1:0] sstat_data,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [FLAG_W-1:0] status,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [DW-1:0]     depth,
    output logic              stack_err
);

    logic [FLAG_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q;
    logic              stack_err_q, stack_err_d;

    stack_op_e         stack_op;
    logic [FLAG_W-1:0] stk_top;
    logic              stk_empty, stk_err, pop_ok;
    logic              stk_full_unused;
    logic              sstat_hi_unused;

    assign stack_op        = decode_stack_op(push, pop);
    assign pop_ok          = (stack_op == STK_POP) && !stk_empty;
    assign sstat_hi_unused = ^sstat_data;

    status_stack #(
        .FLAG_W (FLAG_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .op_i      (stack_op),
        .wr_data_i (status_q),
        .top_o     (stk_top),
        .depth_o   (depth),
        .full_o    (stk_full_unused),
        .empty_o   (stk_empty),
        .err_o     (stk_err)
    );

    always_comb begin
        status_d = status_q;
        if (pop_ok)
            status_d = stk_top;
        else if (sstat_we)
            status_d = sstat_data[FLAG_W-1:0];
        else
            status_d = (status_q & ~alu_flags_we) | (alu_flags & alu_flags_we);
    end

    // A fresh error in the same cycle beats err_clr.
    always_comb begin
        stack_err_d = stack_err_q;
        if (stk_err)
            stack_err_d = 1'b1;
        else if (err_clr)
            stack_err_d = 1'b0;
    end

    always_comb begin
        data_out_d = data_out_q;
        if (lstat_req)
            data_out_d = DATA_W'(status_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q     <= RESET_FLAGS;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            stack_err_q  <= 1'b0;
        end else begin
            status_q     <= status_d;
            data_out_q   <= data_out_d;
            data_valid_q <= lstat_req;
            stack_err_q  <= stack_err_d;
        end
    end

    assign status     = status_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_status_reg_unit.sv
// Directed test of status_reg_unit: reset, LSTAT/SSTAT, masked ALU update,
// stack save/restore, overflow/underflow/conflict and reset during activity.
module tb_status_reg_unit;

    localparam int FLAG_W = 8;
    localparam int DATA_W = 20;
    localparam int SD     = 4;
    localparam int DW     = $clog2(SD + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLAG_W-1:0] alu_flags, alu_flags_we;
    logic              lstat_req, sstat_we, push, pop, err_clr;
    logic [DATA_W-1:0] sstat_data;
    logic [FLAG_W-1:0] status;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [DW-1:0]     depth;
    logic              stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    status_reg_unit #(
        .FLAG_W      (FLAG_W),
        .DATA_W      (DATA_W),
        .STACK_DEPTH (SD),
        .RESET_FLAGS (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_flags    (alu_flags),
        .alu_flags_we (alu_flags_we),
        .lstat_req    (lstat_req),
        .sstat_we     (sstat_we),
        .sstat_data   (sstat_data),
        .push         (push),
        .pop          (pop),
        .err_clr      (err_clr),
        .status       (status),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .depth        (depth),
        .stack_err    (stack_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_flags    = '0;
        alu_flags_we = '0;
        lstat_req    = 1'b0;
        sstat_we     = 1'b0;
        sstat_data   = '0;
        push         = 1'b0;
        pop          = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic sstat(input logic [DATA_W-1:0] v);
        idle();
        sstat_we   = 1'b1;
        sstat_data = v;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_status", 32'(status), 32'h00);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);

        // LSTAT straight after reset
        lstat_req = 1'b1;
        step();
        idle();
        chk("lstat0_data", 32'(data_out), 32'h00000);
        chk("lstat0_valid", 32'(data_valid), 32'h1);
        step();
        chk("lstat0_valid_drop", 32'(data_valid), 32'h0);

        // SSTAT ignores upper bus bits; LSTAT zero-extends
        sstat(20'hABCFF);
        chk("sstat_ff", 32'(status), 32'hFF);
        lstat_req = 1'b1;
        step();
        idle();
        chk("lstat_ff_data", 32'(data_out), 32'h000FF);
        chk("lstat_ff_valid", 32'(data_valid), 32'h1);
        step();
        chk("lstat_hold", 32'(data_out), 32'h000FF);
        alu_flags = 8'h00; alu_flags_we = 8'h0F;
        step();
        idle();
        chk("alu_mask_0f", 32'(status), 32'hF0);
        alu_flags = 8'h35; alu_flags_we = 8'h3C;
        step();
        idle();
        chk("alu_mask_3c", 32'(status), 32'hF4);

        // Push/pop restore
        sstat(20'h11);
        push = 1'b1; step(); idle();
        sstat(20'h22);
        push = 1'b1; step(); idle();
        sstat(20'h33);
        chk("stk_depth2", 32'(depth), 32'h2);
        pop = 1'b1; step(); idle();
        chk("pop1_status", 32'(status), 32'h22);
        chk("pop1_depth", 32'(depth), 32'h1);
        pop = 1'b1; step(); idle();
        chk("pop2_status", 32'(status), 32'h11);
        chk("pop2_depth", 32'(depth), 32'h0);
        chk("pop2_err", 32'(stack_err), 32'h0);

        // Push saves the pre-update value while SSTAT still lands
        push = 1'b1; sstat_we = 1'b1; sstat_data = 20'h44;
        step(); idle();
        chk("push_sstat_status", 32'(status), 32'h44);
        pop = 1'b1; step(); idle();
        chk("push_sstat_restore", 32'(status), 32'h11);

        // Overflow, err_clr, underflow
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; step(); idle();
        end
        chk("fill_depth", 32'(depth), 32'h4);
        chk("fill_err", 32'(stack_err), 32'h0);
        push = 1'b1; step(); idle();
        chk("ovf_depth", 32'(depth), 32'h4);
        chk("ovf_err", 32'(stack_err), 32'h1);
        err_clr = 1'b1; step(); idle();
        chk("errclr", 32'(stack_err), 32'h0);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; step(); idle();
        end
        chk("drain_depth", 32'(depth), 32'h0);
        chk("drain_status", 32'(status), 32'h11);
        pop = 1'b1; step(); idle();
        chk("udf_err", 32'(stack_err), 32'h1);
        chk("udf_status", 32'(status), 32'h11);
        chk("udf_depth", 32'(depth), 32'h0);
        pop = 1'b1; err_clr = 1'b1; step(); idle();
        chk("err_set_wins", 32'(stack_err), 32'h1);
        pop = 1'b1; sstat_we = 1'b1; sstat_data = 20'h66; err_clr = 1'b1;
        step(); idle();
        chk("udf_sstat_status", 32'(status), 32'h66);
        err_clr = 1'b1; step(); idle();
        chk("errclr2", 32'(stack_err), 32'h0);

        // Pop beats SSTAT and ALU
        sstat(20'h5A);
        push = 1'b1; step(); idle();
        sstat(20'h00);
        pop = 1'b1; sstat_we = 1'b1; sstat_data = 20'hC3;
        alu_flags = 8'h0F; alu_flags_we = 8'hFF;
        step(); idle();
        chk("prio_status", 32'(status), 32'h5A);
        chk("prio_depth", 32'(depth), 32'h0);
        chk("prio_err", 32'(stack_err), 32'h0);

        // push && pop conflict
        push = 1'b1; step(); idle();
        push = 1'b1; pop = 1'b1; alu_flags = 8'h81; alu_flags_we = 8'hFF;
        step(); idle();
        chk("conf_depth", 32'(depth), 32'h1);
        chk("conf_err", 32'(stack_err), 32'h1);
        chk("conf_status", 32'(status), 32'h81);
        lstat_req = 1'b1; step(); idle();
        chk("lstat81_data", 32'(data_out), 32'h00081);

        // Reset overrides an in-flight push and LSTAT at depth 2
        push = 1'b1; step(); idle();
        chk("pre_rst_depth", 32'(depth), 32'h2);
        rst_n = 1'b0; push = 1'b1; lstat_req = 1'b1;
        step();
        idle();
        rst_n = 1'b1;
        chk("mid_rst_depth", 32'(depth), 32'h0);
        chk("mid_rst_status", 32'(status), 32'h00);
        chk("mid_rst_valid", 32'(data_valid), 32'h0);
        chk("mid_rst_data", 32'(data_out), 32'h0);
        chk("mid_rst_err", 32'(stack_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
